// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter family.
// - state_e   : serializer FSM encoding (IDLE=0, STREAM=1)
// - idx_width : element-index width, $clog2(N), floored at 1 bit
// - elem_lsb  : packed-vector convention, element i lives at [i*DW +: DW]
package sorter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned dw);
        return i * dw;
    endfunction

endpackage

// File: rtl/order_checker.sv
// Running sort-order check over the element stream of one frame.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : a new frame is captured this cycle (clears frame_bad)
//   fire       : current beat is accepted downstream
//   data       : current element
//   idx        : index of the current element within its frame
//   err        : last beat of a frame that broke the required order
module order_checker
    import sorter_pkg::*;
#(
    parameter int unsigned DW        = 3,
    parameter int unsigned N         = 4,
    parameter int unsigned ASCENDING = 1,
    parameter int unsigned IW        = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fire,
    input  logic [DW-1:0] data,
    input  logic [IW-1:0] idx,
    output logic          err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [DW-1:0] prev;
    logic          frame_bad;
    logic          last;
    logic          viol;

    assign last = (idx == LAST_IDX);

    // Element 0 has no predecessor; equal neighbours are always legal.
    assign viol = (idx != '0) &&
                  ((ASCENDING != 0) ? (data < prev) : (data > prev));

    assign err = last & (frame_bad | viol);

    // prev tracks the last accepted element; frame_bad accumulates earlier violations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (start) begin
                frame_bad <= 1'b0;
            end else if (fire && !last) begin
                prev      <= data;
                frame_bad <= frame_bad | viol;
            end
        end
    end

endmodule

// File: rtl/sorted_frame_serializer.sv
// Captures one packed N-element frame per handshake and streams it out
// element 0 first, one DW-bit element per beat, flagging order errors on
// the last beat of each frame.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_data     : packed frame input (element i at [i*DW +: DW])
//   out_valid/out_ready/out_data  : element stream output
//   out_first/out_last            : beat is element 0 / element N-1
//   out_err                       : with out_last, frame violated order
//   err_sticky                    : any frame ever errored since reset
//   frame_cnt                     : completed frames, wraps
module sorted_frame_serializer
    import sorter_pkg::*;
#(
    parameter int unsigned DW        = 3,
    parameter int unsigned N         = 4,
    parameter int unsigned ASCENDING = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*DW-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned   IW       = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e          state;
    logic [IW-1:0]   idx;
    logic [N*DW-1:0] buffer;
    logic            in_fire;
    logic            out_fire;
    logic            at_last;
    logic            chk_err;

    assign at_last   = (idx == LAST_IDX);
    assign out_valid = (state == ST_STREAM);
    assign out_data  = buffer[elem_lsb(32'(idx), DW) +: DW];
    assign out_first = out_valid & (idx == '0);
    assign out_last  = out_valid & at_last;
    assign out_err   = out_valid & chk_err;

    // Ready on the final beat lets the next frame load with no bubble.
    assign in_ready = (state == ST_IDLE) | ((state == ST_STREAM) & at_last & out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    order_checker #(
        .DW        (DW),
        .N         (N),
        .ASCENDING (ASCENDING),
        .IW        (IW)
    ) u_order_checker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (in_fire),
        .fire  (out_fire),
        .data  (out_data),
        .idx   (idx),
        .err   (chk_err)
    );

    // Frame buffer, element index and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            buffer     <= '0;
            err_sticky <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        buffer <= in_data;
                        idx    <= '0;
                        state  <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_fire) begin
                        if (!at_last) begin
                            idx <= idx + IW'(1);
                        end else begin
                            frame_cnt  <= frame_cnt + CNT_W'(1);
                            err_sticky <= err_sticky | out_err;
                            idx        <= '0;
                            if (in_fire) begin
                                buffer <= in_data;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_frame_serializer.sv
// Scoreboard bench: an ascending DUT and a descending DUT (narrow frame
// counter, so it wraps) share all stimulus; expected beats are pushed when a
// frame is accepted and a negedge monitor pops and compares them.
module tb_sorted_frame_serializer;

    localparam int unsigned DW   = 3;
    localparam int unsigned N    = 4;
    localparam int unsigned CW_A = 16;
    localparam int unsigned CW_D = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [N*DW-1:0] in_data;
    logic            out_ready;

    logic            in_ready_a, out_valid_a, out_first_a, out_last_a, out_err_a, err_sticky_a;
    logic [DW-1:0]   out_data_a;
    logic [CW_A-1:0] frame_cnt_a;
    logic            in_ready_d, out_valid_d, out_first_d, out_last_d, out_err_d, err_sticky_d;
    logic [DW-1:0]   out_data_d;
    logic [CW_D-1:0] frame_cnt_d;

    sorted_frame_serializer #(.DW(DW), .N(N), .ASCENDING(1), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_first(out_first_a), .out_last(out_last_a), .out_err(out_err_a),
        .err_sticky(err_sticky_a), .frame_cnt(frame_cnt_a)
    );

    sorted_frame_serializer #(.DW(DW), .N(N), .ASCENDING(0), .CNT_W(CW_D)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
        .out_first(out_first_d), .out_last(out_last_d), .out_err(out_err_d),
        .err_sticky(err_sticky_d), .frame_cnt(frame_cnt_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            first;
        bit            last;
        bit            err_a;
        bit            err_d;
    } exp_t;

    exp_t sbq[$];
    int   tests     = 0;
    int   fails     = 0;
    int   beats     = 0;
    int   cnt_model = 0;
    bit   sticky_a  = 1'b0;
    bit   sticky_d  = 1'b0;
    bit   rdy_rand  = 1'b0;

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // True when any neighbour pair breaks the requested ordering.
    function automatic bit frame_bad(input logic [N*DW-1:0] f, input bit asc);
        int e[N];
        for (int i = 0; i < N; i++) e[i] = int'(f[i*DW +: DW]);
        for (int i = 1; i < N; i++) begin
            if (asc ? (e[i] < e[i-1]) : (e[i] > e[i-1])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_frame(input logic [N*DW-1:0] f);
        exp_t x;
        bit   bad_a, bad_d;
        bad_a = frame_bad(f, 1'b1);
        bad_d = frame_bad(f, 1'b0);
        for (int i = 0; i < N; i++) begin
            x.data  = f[i*DW +: DW];
            x.first = (i == 0);
            x.last  = (i == N - 1);
            x.err_a = x.last && bad_a;
            x.err_d = x.last && bad_d;
            sbq.push_back(x);
        end
    endtask

    // Called and returns at posedge+1; leaves in_valid high for the caller.
    task automatic send_frame(input logic [N*DW-1:0] f);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = f;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            #1;
            if (in_ready_a) begin
                push_frame(f);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int target);
        for (int c = 0; c < 300 && beats < target; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("beat_wait", int'(beats >= target), 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 500 && sbq.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain", sbq.size(), 0);
    endtask

    function automatic logic [N*DW-1:0] rand_frame();
        int e[N];
        int t;
        int kind;
        logic [N*DW-1:0] f;
        kind = int'($urandom_range(0, 2));
        for (int i = 0; i < N; i++) e[i] = int'($urandom_range(0, (1 << DW) - 1));
        if (kind != 2) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N - 1 - i; j++)
                    if ((kind == 0) ? (e[j] > e[j+1]) : (e[j] < e[j+1])) begin
                        t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                    end
        end
        for (int i = 0; i < N; i++) f[i*DW +: DW] = DW'(e[i]);
        return f;
    endfunction

    // Random sink backpressure when enabled.
    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: counters, handshakes and beat contents at every negedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   exp_ir;
        if (rst_n) begin
            check_eq("frame_cnt_a", int'(frame_cnt_a), cnt_model % (1 << CW_A));
            check_eq("frame_cnt_d", int'(frame_cnt_d), cnt_model % (1 << CW_D));
            check_eq("err_sticky_a", int'(err_sticky_a), int'(sticky_a));
            check_eq("err_sticky_d", int'(err_sticky_d), int'(sticky_d));
            exp_ir = int'((sbq.size() == 0) || (sbq.size() == 1 && out_ready));
            check_eq("in_ready_a", int'(in_ready_a), exp_ir);
            check_eq("in_ready_d", int'(in_ready_d), exp_ir);
            check_eq("out_valid_a", int'(out_valid_a), int'(sbq.size() != 0));
            check_eq("out_valid_d", int'(out_valid_d), int'(sbq.size() != 0));
            if (sbq.size() != 0 && out_valid_a) begin
                e = sbq[0];
                check_eq("out_data_a", int'(out_data_a), int'(e.data));
                check_eq("out_data_d", int'(out_data_d), int'(e.data));
                check_eq("out_first_a", int'(out_first_a), int'(e.first));
                check_eq("out_first_d", int'(out_first_d), int'(e.first));
                check_eq("out_last_a", int'(out_last_a), int'(e.last));
                check_eq("out_last_d", int'(out_last_d), int'(e.last));
                check_eq("out_err_a", int'(out_err_a), int'(e.err_a));
                check_eq("out_err_d", int'(out_err_d), int'(e.err_d));
                if (out_ready) begin
                    void'(sbq.pop_front());
                    beats++;
                    if (e.last) begin
                        cnt_model++;
                        sticky_a = sticky_a | e.err_a;
                        sticky_d = sticky_d | e.err_d;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid_a), 0);
        check_eq("rst_in_ready", int'(in_ready_a), 1);
        check_eq("rst_frame_cnt", int'(frame_cnt_a), 0);
        check_eq("rst_sticky", int'(err_sticky_a), 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Sorted frame, then an unsorted frame.
        send_frame(12'hCD9);
        in_valid = 1'b0;
        drain();
        send_frame(12'hF2A);
        in_valid = 1'b0;
        drain();

        // Sink stalls for 3 cycles while element 2 is presented.
        base = beats;
        send_frame(12'hCD9);
        in_valid = 1'b0;
        wait_beats(base + 2);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back frames with in_valid held.
        send_frame(12'hCD9);
        send_frame(12'hF2A);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a frame.
        base = beats;
        send_frame(12'hCD9);
        in_valid = 1'b0;
        wait_beats(base + 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid_a", int'(out_valid_a), 0);
        check_eq("midrst_out_valid_d", int'(out_valid_d), 0);
        check_eq("midrst_frame_cnt", int'(frame_cnt_a), 0);
        check_eq("midrst_sticky_a", int'(err_sticky_a), 0);
        check_eq("midrst_sticky_d", int'(err_sticky_d), 0);
        sbq.delete();
        cnt_model = 0;
        sticky_a  = 1'b0;
        sticky_d  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(12'hCD9);
        in_valid = 1'b0;
        drain();

        // Descending-sorted frame: clean for dut_d, error for dut_a.
        send_frame(12'h2DE);
        in_valid = 1'b0;
        drain();
        send_frame(12'hCD9);
        in_valid = 1'b0;
        drain();

        // Randomized frames, gaps with junk data, random backpressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            send_frame(rand_frame());
            if ($urandom_range(0, 1) != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    in_data = N*DW'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
